// File: rtl/score_keeper.sv
// Score, line and level accumulator for the score overlay renderer.
// Optional macro SCORE_HIGHSCORE_EN adds a high_score output that survives new_game.
module score_keeper #(
    parameter int LINES_PER_LEVEL = 10,
    parameter int MAX_LEVEL       = 9,
    parameter int SCORE_MAX       = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       new_game,
    input  logic       clear_valid,
    input  logic [2:0] clear_count,
    output logic       clear_ready,
    output logic [7:0] score,
    output logic [3:0] level,
    output logic [7:0] lines,
    output logic       level_up
`ifdef SCORE_HIGHSCORE_EN
    ,
    output logic [7:0] high_score
`endif
);

    // Handshake: an event transfers on a rising clk edge where clear_valid and
    // clear_ready are both high; the producer holds clear_valid/clear_count stable
    // until then, and clear_ready never depends on clear_valid.

    localparam logic [7:0] SCORE_MAX_V = 8'(SCORE_MAX);
    localparam logic [4:0] LPL_V       = 5'(LINES_PER_LEVEL);
    localparam logic [3:0] MAX_LEVEL_V = 4'(MAX_LEVEL);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_LVL  = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] score_q, score_d;
    logic [3:0] level_q, level_d;
    logic [7:0] lines_q, lines_d;
    logic [4:0] lil_q, lil_d;
    logic [4:0] reps_q, reps_d;
    logic [3:0] base_q, base_d;
    logic       level_up_c;
    logic       accept;
    logic [8:0] lines_sum;
    logic [8:0] score_sum;

    function automatic logic [3:0] base_points(input logic [2:0] c);
        case (c)
            3'd1:    return 4'd1;
            3'd2:    return 4'd3;
            3'd3:    return 4'd5;
            3'd4:    return 4'd8;
            default: return 4'd0;
        endcase
    endfunction

    assign clear_ready = (state_q == S_IDLE);
    assign accept      = clear_valid & clear_ready;
    assign lines_sum   = {1'b0, lines_q} + 9'(clear_count);
    assign score_sum   = {1'b0, score_q} + 9'(base_q);

    always_comb begin
        state_d    = state_q;
        score_d    = score_q;
        level_d    = level_q;
        lines_d    = lines_q;
        lil_d      = lil_q;
        reps_d     = reps_q;
        base_d     = base_q;
        level_up_c = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Counts outside 1..4 are consumed without touching any state.
                if (accept && clear_count >= 3'd1 && clear_count <= 3'd4) begin
                    base_d  = base_points(clear_count);
                    reps_d  = {1'b0, level_q} + 5'd1;
                    lines_d = lines_sum[8] ? 8'hFF : lines_sum[7:0];
                    lil_d   = lil_q + 5'(clear_count);
                    state_d = S_ADD;
                end
            end
            S_ADD: begin
                score_d = (score_sum > {1'b0, SCORE_MAX_V}) ? SCORE_MAX_V : score_sum[7:0];
                reps_d  = reps_q - 5'd1;
                if (reps_q == 5'd1) begin
                    state_d = S_LVL;
                end
            end
            S_LVL: begin
                if (lil_q >= LPL_V) begin
                    lil_d = lil_q - LPL_V;
                    if (level_q < MAX_LEVEL_V) begin
                        level_d    = level_q + 4'd1;
                        level_up_c = 1'b1;
                    end
                end
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A new game wipes everything, including points still being added.
        if (new_game) begin
            state_d    = S_IDLE;
            score_d    = 8'd0;
            level_d    = 4'd0;
            lines_d    = 8'd0;
            lil_d      = 5'd0;
            reps_d     = 5'd0;
            base_d     = 4'd0;
            level_up_c = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            score_q <= 8'd0;
            level_q <= 4'd0;
            lines_q <= 8'd0;
            lil_q   <= 5'd0;
            reps_q  <= 5'd0;
            base_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            score_q <= score_d;
            level_q <= level_d;
            lines_q <= lines_d;
            lil_q   <= lil_d;
            reps_q  <= reps_d;
            base_q  <= base_d;
        end
    end

    assign score    = score_q;
    assign level    = level_q;
    assign lines    = lines_q;
    assign level_up = level_up_c;

`ifdef SCORE_HIGHSCORE_EN
    logic [7:0] high_score_q, high_score_d;

    // Tracks the registered score, so it trails score by one cycle.
    always_comb begin
        high_score_d = (score_q > high_score_q) ? score_q : high_score_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            high_score_q <= 8'd0;
        end else begin
            high_score_q <= high_score_d;
        end
    end

    assign high_score = high_score_q;
`endif

endmodule

// File: tb/tb_score_keeper.sv
// Self-checking bench for score_keeper: randomized clears against a rules-level model.
module tb_score_keeper;

  localparam int LPL  = 10;
  localparam int MAXL = 9;
  localparam int SMAX = 255;

  logic       clk = 1'b0;
  logic       rst;
  logic       new_game;
  logic       clear_valid;
  logic [2:0] clear_count;
  logic       clear_ready;
  logic [7:0] score;
  logic [3:0] level;
  logic [7:0] lines;
  logic       level_up;
`ifdef SCORE_HIGHSCORE_EN
  logic [7:0] high_score;
`endif

  score_keeper #(
    .LINES_PER_LEVEL(LPL),
    .MAX_LEVEL(MAXL),
    .SCORE_MAX(SMAX)
  ) dut (
    .clk(clk),
    .rst(rst),
    .new_game(new_game),
    .clear_valid(clear_valid),
    .clear_count(clear_count),
    .clear_ready(clear_ready),
    .score(score),
    .level(level),
    .lines(lines),
    .level_up(level_up)
`ifdef SCORE_HIGHSCORE_EN
    ,
    .high_score(high_score)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state: game totals as the rules describe them.
  int exp_score, exp_level, exp_lines, exp_lil, exp_hs;

  function automatic int base_of(int c);
    case (c)
      1: return 1;
      2: return 3;
      3: return 5;
      4: return 8;
      default: return 0;
    endcase
  endfunction

  task automatic model_game_clear(input bit also_hs);
    exp_score = 0;
    exp_level = 0;
    exp_lines = 0;
    exp_lil   = 0;
    if (also_hs) exp_hs = 0;
  endtask

  // Applies one event; returns expected busy cycles and expected level_up pulses.
  task automatic model_clear(input int c, output int eb, output int elu);
    eb  = 0;
    elu = 0;
    if (c >= 1 && c <= 4) begin
      eb        = exp_level + 2;
      exp_score = exp_score + base_of(c) * (exp_level + 1);
      if (exp_score > SMAX) exp_score = SMAX;
      exp_lines = exp_lines + c;
      if (exp_lines > 255) exp_lines = 255;
      exp_lil = exp_lil + c;
      if (exp_lil >= LPL) begin
        exp_lil = exp_lil - LPL;
        if (exp_level < MAXL) begin
          exp_level = exp_level + 1;
          elu = 1;
        end
      end
    end
    if (exp_score > exp_hs) exp_hs = exp_score;
  endtask

  // Driver: offers one event, optionally keeps clear_valid up while busy, and
  // reports busy cycles, level_up pulses and the score seen in the last busy cycle.
  task automatic send_clear(input int c, input bit hold, output int busy,
                            output int lu_n, output logic [7:0] last_score);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!clear_ready && guard < 64) begin
      guard++;
      @(negedge clk);
    end
    clear_valid = 1'b1;
    clear_count = 3'(c);
    @(negedge clk);
    if (!hold) clear_valid = 1'b0;
    busy = 0;
    lu_n = 0;
    last_score = score;
    while (!clear_ready && busy < 64) begin
      last_score = score;
      if (level_up === 1'b1) lu_n++;
      busy++;
      @(negedge clk);
    end
    clear_valid = 1'b0;
  endtask

  task automatic do_new_game();
    @(negedge clk);
    new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
    model_game_clear(1'b0);
  endtask

  task automatic test_reset();
    int busy, lu_n, eb, elu;
    logic [7:0] ls;
    rst = 1'b1; new_game = 1'b0; clear_valid = 1'b0; clear_count = 3'd0;
    repeat (2) @(negedge clk);
    checks++; if (score !== 8'd0) begin errors++; $display("FAIL reset_score got=%0d exp=0", score); end
    checks++; if (level !== 4'd0) begin errors++; $display("FAIL reset_level got=%0d exp=0", level); end
    checks++; if (lines !== 8'd0) begin errors++; $display("FAIL reset_lines got=%0d exp=0", lines); end
    checks++; if (clear_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", clear_ready); end
    checks++; if (level_up !== 1'b0) begin errors++; $display("FAIL reset_level_up got=%b exp=0", level_up); end
`ifdef SCORE_HIGHSCORE_EN
    checks++; if (high_score !== 8'd0) begin errors++; $display("FAIL reset_hs got=%0d exp=0", high_score); end
`endif
    rst = 1'b0;
    model_game_clear(1'b1);
    // Accept a 4-line clear, then hit rst while it is still adding.
    @(negedge clk);
    clear_valid = 1'b1; clear_count = 3'd4;
    @(negedge clk);
    clear_valid = 1'b0;
    checks++; if (clear_ready !== 1'b0) begin errors++; $display("FAIL midadd_busy got=%b exp=0", clear_ready); end
    #1 rst = 1'b1;
    #1;
    checks++; if (lines !== 8'd0) begin errors++; $display("FAIL async_rst_lines got=%0d exp=0", lines); end
    checks++; if (score !== 8'd0) begin errors++; $display("FAIL async_rst_score got=%0d exp=0", score); end
    checks++; if (clear_ready !== 1'b1) begin errors++; $display("FAIL async_rst_ready got=%b exp=1", clear_ready); end
    @(negedge clk);
    rst = 1'b0;
    model_clear(1, eb, elu);
    send_clear(1, 1'b0, busy, lu_n, ls);
    checks++; if (busy !== eb) begin errors++; $display("FAIL post_rst_busy got=%0d exp=%0d", busy, eb); end
    checks++; if (score !== 8'(exp_score)) begin errors++; $display("FAIL post_rst_score got=%0d exp=%0d", score, exp_score); end
  endtask

  task automatic test_single_four();
    int busy, lu_n, eb, elu;
    logic [7:0] ls;
    do_new_game();
    model_clear(4, eb, elu);
    send_clear(4, 1'b0, busy, lu_n, ls);
    checks++; if (busy !== 2) begin errors++; $display("FAIL four_busy got=%0d exp=2", busy); end
    checks++; if (score !== 8'd8) begin errors++; $display("FAIL four_score got=%0d exp=8", score); end
    checks++; if (lines !== 8'd4) begin errors++; $display("FAIL four_lines got=%0d exp=4", lines); end
    checks++; if (level !== 4'd0) begin errors++; $display("FAIL four_level got=%0d exp=0", level); end
    checks++; if (ls !== 8'd8) begin errors++; $display("FAIL four_score_at_lvl got=%0d exp=8", ls); end
  endtask

  task automatic test_level_up();
    int busy, lu_n, eb, elu;
    logic [7:0] ls;
    do_new_game();
    for (int i = 0; i < 10; i++) begin
      model_clear(1, eb, elu);
      send_clear(1, 1'b0, busy, lu_n, ls);
      checks++; if (lu_n !== elu) begin errors++; $display("FAIL lvl_pulse ev=%0d got=%0d exp=%0d", i, lu_n, elu); end
    end
    checks++; if (level !== 4'd1) begin errors++; $display("FAIL lvl_level got=%0d exp=1", level); end
    checks++; if (lines !== 8'd10) begin errors++; $display("FAIL lvl_lines got=%0d exp=10", lines); end
    checks++; if (score !== 8'd10) begin errors++; $display("FAIL lvl_score got=%0d exp=10", score); end
    model_clear(2, eb, elu);
    send_clear(2, 1'b1, busy, lu_n, ls);
    checks++; if (busy !== 3) begin errors++; $display("FAIL lvl1_busy got=%0d exp=3", busy); end
    checks++; if (score !== 8'd16) begin errors++; $display("FAIL lvl1_score got=%0d exp=16", score); end
  endtask

  task automatic test_saturation();
    int busy, lu_n, eb, elu, c, n;
    logic [7:0] ls;
    do_new_game();
    n = 0;
    while (exp_score < SMAX && n < 100) begin
      c = $urandom_range(1, 4);
      model_clear(c, eb, elu);
      send_clear(c, 1'b0, busy, lu_n, ls);
      n++;
      checks++; if (busy !== eb || score !== 8'(exp_score) || ls !== 8'(exp_score)) begin
        errors++;
        $display("FAIL sat_step busy=%0d/%0d score=%0d last=%0d exp=%0d", busy, eb, score, ls, exp_score);
      end
    end
    model_clear(1, eb, elu);
    send_clear(1, 1'b0, busy, lu_n, ls);
    checks++; if (score !== 8'(SMAX)) begin errors++; $display("FAIL sat_hold got=%0d exp=%0d", score, SMAX); end
    checks++; if (lines !== 8'(exp_lines)) begin errors++; $display("FAIL sat_lines got=%0d exp=%0d", lines, exp_lines); end
    checks++; if (busy !== eb) begin errors++; $display("FAIL sat_busy got=%0d exp=%0d", busy, eb); end
  endtask

  task automatic test_new_game();
    int busy, lu_n, eb, elu;
    logic [7:0] ls;
    do_new_game();
    while (exp_level < 3) begin
      model_clear(4, eb, elu);
      send_clear(4, 1'b0, busy, lu_n, ls);
    end
    checks++; if (level !== 4'd3) begin errors++; $display("FAIL ng_pre_level got=%0d exp=3", level); end
    @(negedge clk);
    clear_valid = 1'b1; clear_count = 3'd1;
    @(negedge clk);
    // First ADD cycle: abort, and offer an event that must be ignored.
    new_game = 1'b1; clear_count = 3'd4;
    @(negedge clk);
    new_game = 1'b0; clear_valid = 1'b0;
    model_game_clear(1'b0);
    checks++; if (score !== 8'd0) begin errors++; $display("FAIL ng_score got=%0d exp=0", score); end
    checks++; if (level !== 4'd0) begin errors++; $display("FAIL ng_level got=%0d exp=0", level); end
    checks++; if (lines !== 8'd0) begin errors++; $display("FAIL ng_lines got=%0d exp=0", lines); end
    checks++; if (clear_ready !== 1'b1) begin errors++; $display("FAIL ng_ready got=%b exp=1", clear_ready); end
`ifdef SCORE_HIGHSCORE_EN
    checks++; if (high_score !== 8'(exp_hs)) begin errors++; $display("FAIL ng_hs got=%0d exp=%0d", high_score, exp_hs); end
`endif
    repeat (4) @(negedge clk);
    checks++; if (score !== 8'd0 || lines !== 8'd0) begin errors++; $display("FAIL ng_settle score=%0d lines=%0d exp=0", score, lines); end
  endtask

  task automatic test_invalid_count();
    int busy, lu_n, eb, elu;
    logic [7:0] ls;
    int bad [3] = '{0, 5, 7};
    model_clear(3, eb, elu);
    send_clear(3, 1'b0, busy, lu_n, ls);
    foreach (bad[i]) begin
      model_clear(bad[i], eb, elu);
      send_clear(bad[i], 1'b0, busy, lu_n, ls);
      checks++; if (busy !== 0 || clear_ready !== 1'b1) begin errors++; $display("FAIL inv%0d_ready busy=%0d exp=0", bad[i], busy); end
      checks++; if (score !== 8'(exp_score) || lines !== 8'(exp_lines) || level !== 4'(exp_level)) begin
        errors++;
        $display("FAIL inv%0d_state score=%0d/%0d lines=%0d/%0d level=%0d/%0d", bad[i], score, exp_score, lines, exp_lines, level, exp_level);
      end
    end
  endtask

  task automatic test_random_back_to_back();
    int busy, lu_n, eb, elu, c;
    bit hold;
    logic [7:0] ls;
    do_new_game();
    for (int i = 0; i < 90; i++) begin
      c    = (i < 30) ? 4 : $urandom_range(0, 7);
      hold = 1'($urandom_range(0, 1));
      model_clear(c, eb, elu);
      send_clear(c, hold, busy, lu_n, ls);
      checks++; if (busy !== eb || lu_n !== elu) begin
        errors++;
        $display("FAIL rnd_timing ev=%0d busy=%0d/%0d pulses=%0d/%0d", i, busy, eb, lu_n, elu);
      end
      checks++; if (score !== 8'(exp_score) || ls !== 8'(exp_score) || lines !== 8'(exp_lines) || level !== 4'(exp_level)) begin
        errors++;
        $display("FAIL rnd_state ev=%0d score=%0d/%0d last=%0d lines=%0d/%0d level=%0d/%0d",
                 i, score, exp_score, ls, lines, exp_lines, level, exp_level);
      end
`ifdef SCORE_HIGHSCORE_EN
      checks++; if (high_score !== 8'(exp_hs)) begin errors++; $display("FAIL rnd_hs ev=%0d got=%0d exp=%0d", i, high_score, exp_hs); end
`endif
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    checks++; if (level !== 4'(MAXL)) begin errors++; $display("FAIL max_level got=%0d exp=%0d", level, MAXL); end
  endtask

  initial begin
    test_reset();
    test_single_four();
    test_level_up();
    test_saturation();
    test_new_game();
    test_invalid_count();
    test_random_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
